program_counter: RTL and testbench

Holds the 10-bit instruction address and selects the next fetch address from sequential, branch, jump and register-jump sources. Implements run/wait-for-input/halt control for the processor. Drives `ProximoPC` (PC+1) to the write-back JAL/JALR selection stage, where the return address is written to the register file. Sits at the head of the fetch path, between the control unit/ALU and instruction memory.

---
 rtl/processador_pkg.sv | 14 +
 rtl/confirma_sync.sv | 36 +++
 rtl/program_counter.sv | 101 ++++++++++
 tb/tb_program_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/processador_pkg.sv
// Shared definitions for the processor fetch path: PC control states and default sizes.
package processador_pkg;

    localparam int PC_ADDR_W_DEF = 10;
    localparam int PC_RESET_DEF  = 0;
    localparam int REG_W         = 32;

    typedef enum logic [1:0] {
        EXEC   = 2'd0,
        ESPERA = 2'd1,
        PARADO = 2'd2
    } pc_state_t;

endpackage

// File: rtl/confirma_sync.sv
// Operator confirm conditioning: 2-flop synchronizer plus rising-edge detector when
// PC_CONFIRM_SYNC_EN is defined, otherwise a plain pass-through of a synchronous pulse.
module confirma_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_confirma,
    output logic o_pulse
);

`ifdef PC_CONFIRM_SYNC_EN
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_confirma;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // A held button yields a single pulse; holding it across ESPERA entry yields none.
    assign o_pulse = r_sync2 & ~r_prev;
`else
    logic w_unused_clk_rst;

    assign w_unused_clk_rst = i_clk ^ i_rst_n;
    assign o_pulse          = i_confirma;
`endif

endmodule

// File: rtl/program_counter.sv
// Instruction address register with run / wait-for-input / halt control.
// Build option: PC_CONFIRM_SYNC_EN enables synchronization of the Confirma button.
//
// state  | meaning
// EXEC   | fetching: PC advances, branches or jumps every cycle
// ESPERA | IN instruction stalled, waiting for operator confirm
// PARADO | HLT executed, frozen until reset
module program_counter
    import processador_pkg::*;
#(
    parameter int ADDR_W   = PC_ADDR_W_DEF,
    parameter int RESET_PC = PC_RESET_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Halt,
    input  logic              Input,
    input  logic              Confirma,
    input  logic              Branch,
    input  logic              JUMP,
    input  logic              JUMPAL,
    input  logic              JALR,
    input  logic [ADDR_W-1:0] Imediato,
    input  logic [REG_W-1:0]  RegAlvo,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] ProximoPC,
    output logic              Pausado,
    output logic              Parado
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    pc_state_t         r_state;
    pc_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_confirma;
    logic              w_unused_regalvo;

    confirma_sync u_confirma_sync (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_confirma (Confirma),
        .o_pulse    (w_confirma)
    );

    assign w_pc_inc         = r_pc + ADDR_W'(1);
    assign w_unused_regalvo = ^RegAlvo[REG_W-1:ADDR_W];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= EXEC;
            r_pc    <= RESET_ADDR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            EXEC: begin
                if (Halt) begin
                    w_state_nxt = PARADO;
                end else if (Input) begin
                    w_state_nxt = ESPERA;
                end else if (JALR) begin
                    w_pc_nxt = RegAlvo[ADDR_W-1:0];
                end else if (JUMP || JUMPAL) begin
                    w_pc_nxt = Imediato;
                end else if (Branch) begin
                    w_pc_nxt = Imediato;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            ESPERA: begin
                if (w_confirma) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = EXEC;
                end
            end
            PARADO: begin
                w_state_nxt = PARADO;
            end
            // unused encoding falls back to fetching
            default: begin
                w_state_nxt = EXEC;
            end
        endcase
    end

    assign PC        = r_pc;
    assign ProximoPC = w_pc_inc;
    assign Pausado   = (r_state == ESPERA);
    assign Parado    = (r_state == PARADO);

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: stimulus queues expected state, monitor checks on negedge.
module tb_program_counter;

    logic        clock;
    logic        reset;
    logic        Halt, Input, Confirma, Branch, JUMP, JUMPAL, JALR;
    logic [9:0]  Imediato;
    logic [31:0] RegAlvo;
    logic [9:0]  PC, ProximoPC;
    logic        Pausado, Parado;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      nm;
        logic [9:0] pc;
        logic       pau;
        logic       par;
    } exp_t;

    exp_t sb[$];

    program_counter dut (
        .clock     (clock),
        .reset     (reset),
        .Halt      (Halt),
        .Input     (Input),
        .Confirma  (Confirma),
        .Branch    (Branch),
        .JUMP      (JUMP),
        .JUMPAL    (JUMPAL),
        .JALR      (JALR),
        .Imediato  (Imediato),
        .RegAlvo   (RegAlvo),
        .PC        (PC),
        .ProximoPC (ProximoPC),
        .Pausado   (Pausado),
        .Parado    (Parado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin : monitor
        exp_t       e;
        logic [9:0] enx;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            enx = e.pc + 10'd1;
            checks++;
            if (PC !== e.pc || ProximoPC !== enx || Pausado !== e.pau || Parado !== e.par) begin
                errors++;
                $display("FAIL %s: got PC=%0d ProximoPC=%0d Pausado=%b Parado=%b, want PC=%0d ProximoPC=%0d Pausado=%b Parado=%b",
                         e.nm, PC, ProximoPC, Pausado, Parado, e.pc, enx, e.pau, e.par);
            end
        end
    end

    task automatic push(input string nm, input logic [9:0] pc, input logic pau, input logic par);
        exp_t e;
        e.nm  = nm;
        e.pc  = pc;
        e.pau = pau;
        e.par = par;
        sb.push_back(e);
    endtask

    // advance one edge with the inputs currently driven, then expect the post-edge state
    task automatic cyc(input string nm, input logic [9:0] pc, input logic pau, input logic par);
        @(posedge clock);
        #1;
        push(nm, pc, pau, par);
    endtask

    task automatic clr();
        Halt = 0; Input = 0; Confirma = 0; Branch = 0;
        JUMP = 0; JUMPAL = 0; JALR = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 0;
        clr();
        Imediato = 10'd0;
        RegAlvo  = 32'd0;
        #1;
        push("reset", 10'd0, 1'b0, 1'b0);
        @(posedge clock);
        #2 reset = 1;

        for (int i = 1; i <= 5; i++) cyc("seq", 10'(i), 1'b0, 1'b0);

        JUMP = 1; Imediato = 10'd1023;
        cyc("jump_1023", 10'd1023, 1'b0, 1'b0);
        clr();
        cyc("wrap", 10'd0, 1'b0, 1'b0);

        JALR = 1; RegAlvo = 32'hFFFF_F07B; JUMP = 1; Imediato = 10'd5; Branch = 1;
        cyc("jalr_prio", 10'd123, 1'b0, 1'b0);
        clr();
        JUMPAL = 1; Imediato = 10'd500;
        cyc("jumpal", 10'd500, 1'b0, 1'b0);
        clr();
        Branch = 1; Imediato = 10'd40;
        cyc("branch", 10'd40, 1'b0, 1'b0);
        clr();

        Input = 1;
        cyc("input", 10'd40, 1'b1, 1'b0);
        clr();
        Imediato = 10'd77;
        for (int i = 0; i < 20; i++) begin
            Branch = i[0];
            JUMP   = i[1];
            cyc("espera_hold", 10'd40, 1'b1, 1'b0);
        end
        clr();
        Confirma = 1;
`ifdef PC_CONFIRM_SYNC_EN
        cyc("conf_sync1", 10'd40, 1'b1, 1'b0);
        cyc("conf_sync2", 10'd40, 1'b1, 1'b0);
`endif
        cyc("confirm", 10'd41, 1'b0, 1'b0);
        cyc("conf_held", 10'd42, 1'b0, 1'b0);
`ifdef PC_CONFIRM_SYNC_EN
        Input = 1;
        cyc("in_held", 10'd42, 1'b1, 1'b0);
        Input = 0;
        repeat (4) cyc("held_no_release", 10'd42, 1'b1, 1'b0);
        Confirma = 0;
        repeat (2) cyc("released_wait", 10'd42, 1'b1, 1'b0);
        Confirma = 1;
        cyc("repress_e1", 10'd42, 1'b1, 1'b0);
        cyc("repress_e2", 10'd42, 1'b1, 1'b0);
        cyc("repress_e3", 10'd43, 1'b0, 1'b0);
`endif
        clr();

        JUMP = 1; Imediato = 10'd7;
        cyc("jump7", 10'd7, 1'b0, 1'b0);
        clr();
        Halt = 1; Input = 1;
        cyc("halt_input", 10'd7, 1'b0, 1'b1);
        clr();
        Imediato = 10'd99;
        for (int i = 0; i < 50; i++) begin
            JUMP     = 1;
            Confirma = i[0];
            Input    = i[1];
            JALR     = i[2];
            cyc("parado_hold", 10'd7, 1'b0, 1'b1);
        end
        clr();

        @(posedge clock);
        #3 reset = 0;
        #1 push("async_rst", 10'd0, 1'b0, 1'b0);
        cyc("rst_held", 10'd0, 1'b0, 1'b0);
        #1 reset = 1;
        cyc("post_rst", 10'd1, 1'b0, 1'b0);

        Halt = 1; JALR = 1; RegAlvo = 32'd300;
        cyc("halt_jalr", 10'd1, 1'b0, 1'b1);
        clr();
        cyc("halt_stay", 10'd1, 1'b0, 1'b1);

        @(posedge clock);
        #3 reset = 0;
        #1 push("rst_parado", 10'd0, 1'b0, 1'b0);
        #2 reset = 1;
        cyc("run", 10'd1, 1'b0, 1'b0);
        Input = 1;
        cyc("in2", 10'd1, 1'b1, 1'b0);
        clr();
        cyc("in2_hold", 10'd1, 1'b1, 1'b0);

        @(posedge clock);
        #3 Confirma = 1; reset = 0;
        #1 push("rst_espera", 10'd0, 1'b0, 1'b0);
        #2 reset = 1;
        cyc("no_spur1", 10'd1, 1'b0, 1'b0);
        cyc("no_spur2", 10'd2, 1'b0, 1'b0);
        Confirma = 0;
        cyc("no_spur3", 10'd3, 1'b0, 1'b0);
        cyc("no_spur4", 10'd4, 1'b0, 1'b0);

        begin : drain
            int n;
            n = 0;
            while (sb.size() > 0 && n < 10) begin
                @(negedge clock);
                n++;
            end
            #1;
            if (sb.size() > 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
